instr_fetch_unit: RTL and testbench

- Produces the instruction stream that the control unit decodes.
- Issues word fetches to instruction memory, buffers returned words with their PC in a small prefetch FIFO, and presents them to decode with a valid/ready handshake.
- Consumes the decoder's taken-branch/jump redirect (PCSrc plus target), flushes stale instructions and restarts fetch at the target.

---
 rtl/instr_fetch_unit.sv | 174 +++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches instruction words, buffers {word, pc} in a small
// prefetch FIFO and hands them to decode over a valid/ready handshake.
// Taken-branch redirects flush the FIFO and restart fetch at the target.
// Optional build macro: FETCH_MISALIGN_CHECK_EN adds the fetch_misalign output
// and halts fetch on a redirect target that is not word aligned.
module instr_fetch_unit #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'hBFC00000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        fetch_misalign
`endif
);

  localparam int unsigned    PW      = $clog2(DEPTH);
  localparam int unsigned    CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]    state_q, state_d;
  // fetch_pc_q: next address to request once the current request is done
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  // req_addr_q: address presented on mem_addr / owned by the outstanding request
  logic [31:0]   req_addr_q, req_addr_d;
  logic          drop_q, drop_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];
  logic          push, pop, start_req, halt;
  logic [31:0]   target;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  // Every redirect re-evaluates alignment; only an aligned one clears the halt
  always_comb begin
    misalign_d = misalign_q;
    if (redirect_valid) misalign_d = (redirect_pc[1:0] != 2'b00);
  end

  // Sticky misalignment flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end

  assign fetch_misalign = misalign_q;
  assign halt           = misalign_d;
`else
  // Target low bits are simply discarded in this build
  logic unused_pc_bits;
  assign unused_pc_bits = ^redirect_pc[1:0];
  assign halt           = 1'b0;
`endif

  // Next-state: response/drop handling, FIFO bookkeeping and fetch sequencing
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    drop_d     = drop_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    push       = 1'b0;
    start_req  = 1'b0;
    pop        = instr_valid & instr_ready;
    target     = {redirect_pc[31:2], 2'b00};

    if (redirect_valid) fetch_pc_d = target;

    // A response arriving with a redirect is stale; otherwise a redirect marks
    // the single in-flight (or about-to-be-accepted) request for discard.
    if (state_q == ST_WAIT) begin
      if (mem_rvalid) begin
        push   = ~drop_q & ~redirect_valid;
        drop_d = 1'b0;
      end else if (redirect_valid) begin
        drop_d = 1'b1;
      end
    end else if (state_q == ST_REQ && redirect_valid) begin
      drop_d = 1'b1;
    end

    if (redirect_valid) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end

    // Outstanding is zero whenever a new request is considered, so free slots
    // are simply DEPTH minus the post-update occupancy.
    case (state_q)
      ST_IDLE: start_req = ~halt & (count_d < DEPTH_C);
      ST_REQ:  if (mem_ready) state_d = ST_WAIT;
      ST_WAIT: begin
        if (mem_rvalid) begin
          start_req = ~halt & (count_d < DEPTH_C);
          if (!start_req) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Latch the request address now and advance, so a later redirect while
    // the request waits for acceptance cannot disturb mem_addr.
    if (start_req) begin
      state_d    = ST_REQ;
      req_addr_d = fetch_pc_d;
      fetch_pc_d = fetch_pc_d + 32'd4;
    end
  end

  // Control and pointer state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      drop_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage: word plus the PC of the request that fetched it
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= mem_rdata;
      pc_mem[wr_ptr_q]    <= req_addr_q;
    end
  end

  assign mem_req     = (state_q == ST_REQ);
  assign mem_addr    = req_addr_q;
  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? instr_mem[rd_ptr_q] : NOP_INSTR;
  assign instr_pc    = instr_valid ? pc_mem[rd_ptr_q] : 32'h0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scenarios plus randomized traffic, checked
// against a stream-level model (delivered PCs are consecutive from the last
// redirect target, each word equals the memory image at its PC).
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'hBFC00000;
  localparam logic [31:0] NOP      = 32'h00000013;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_misalign;
`endif

  instr_fetch_unit #(.DEPTH(4), .RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ready      (mem_ready),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .fetch_misalign (fetch_misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_pops   = 0;
  int unsigned pops_since_rst = 0;
  logic [31:0] first_pop_pc;
  logic [31:0] exp_pc;
  logic [31:0] pend_q[$];
  logic [31:0] acc_q[$];
  bit          stall_prev;
  logic [31:0] stall_addr;
  bit          stray;
  bit          corrupt;
  bit          seen_dead;
  bit          verbose;

  // Memory image: every address holds a distinct, address-derived word
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'h5EED0000) + {a[15:0], a[31:16]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    pend_q.delete();
    acc_q.delete();
    exp_pc         = RESET_PC;
    stall_prev     = 1'b0;
    pops_since_rst = 0;
    stray          = 1'b0;
    corrupt        = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_mem_req"},  32'(mem_req), 32'd0);
    check_eq({pfx, "_mem_addr"}, mem_addr, RESET_PC);
    check_eq({pfx, "_valid"},    32'(instr_valid), 32'd0);
    check_eq({pfx, "_instr"},    instr, NOP);
    check_eq({pfx, "_pc"},       instr_pc, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0; mem_rvalid = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    model_reset();
  endtask

  // One clock: drive inputs just after negedge, sample, update model, advance.
  task automatic cycle(input bit rdy, input bit rv, input bit ird, input bit redir,
                       input logic [31:0] rpc);
    bit from_pend;
    from_pend      = 1'b0;
    mem_ready      = rdy;
    instr_ready    = ird;
    redirect_valid = redir;
    redirect_pc    = rpc;
    mem_rvalid     = 1'b0;
    mem_rdata      = $urandom;
    if (rv && stray) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hBAD0BAD0;
      stray      = 1'b0;
    end else if (rv && pend_q.size() != 0) begin
      mem_rvalid = 1'b1;
      mem_rdata  = corrupt ? 32'hDEADBEEF : mem_word(pend_q[0]);
      corrupt    = 1'b0;
      from_pend  = 1'b1;
    end
    #1;
    if (!instr_valid) check_eq("nop_when_idle", instr, NOP);
    if (mem_req) check_eq("one_outstanding", 32'(pend_q.size()), 32'd0);
    if (stall_prev) begin
      check_eq("req_hold", 32'(mem_req), 32'd1);
      check_eq("addr_hold", mem_addr, stall_addr);
    end
    if (instr_valid && instr == 32'hDEADBEEF) seen_dead = 1'b1;
    if (instr_valid && ird) begin
      check_eq("pop_pc", instr_pc, exp_pc);
      check_eq("pop_instr", instr, mem_word(exp_pc));
      if (verbose) $display("[%0t] pop pc=%h instr=%h", $time, instr_pc, instr);
      if (pops_since_rst == 0) first_pop_pc = instr_pc;
      pops_since_rst++;
      n_pops++;
      exp_pc = exp_pc + 32'd4;
    end
    if (from_pend) void'(pend_q.pop_front());
    if (mem_req && rdy) begin
      pend_q.push_back(mem_addr);
      acc_q.push_back(mem_addr);
    end
    stall_prev = mem_req && !rdy;
    stall_addr = mem_addr;
    if (redir) exp_pc = {rpc[31:2], 2'b00};
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    rst = 1'b1;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    seen_dead = 1'b0;
    verbose = 1'b1;
    first_pop_pc = 32'h0;
    model_reset();

    // Latency from reset release and first addresses
    do_reset();
    cycle(1, 1, 0, 0, 0);
    check_eq("lat_c1_valid", 32'(instr_valid), 32'd0);
    cycle(1, 1, 0, 0, 0);
    check_eq("lat_c2_valid", 32'(instr_valid), 32'd0);
    cycle(1, 1, 0, 0, 0);
    check_eq("lat_c3_valid", 32'(instr_valid), 32'd1);
    check_eq("lat_first_pc", instr_pc, RESET_PC);
    check_eq("lat_addr0", acc_q[0], RESET_PC);

    // Decode stalled: exactly DEPTH requests, then one pop frees one slot
    repeat (12) cycle(1, 1, 0, 0, 0);
    check_eq("full_acc_count", 32'(acc_q.size()), 32'd4);
    check_eq("full_addr1", acc_q[1], RESET_PC + 32'd4);
    check_eq("full_addr3", acc_q[3], RESET_PC + 32'd12);
    check_eq("full_no_req", 32'(mem_req), 32'd0);
    cycle(1, 1, 1, 0, 0);
    repeat (8) cycle(1, 1, 0, 0, 0);
    check_eq("refill_acc_count", 32'(acc_q.size()), 32'd5);
    check_eq("refill_addr", acc_q[4], RESET_PC + 32'd16);
    check_eq("refill_no_req", 32'(mem_req), 32'd0);

    // Redirect while waiting; stale response must be discarded
    do_reset();
    seen_dead = 1'b0;
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 32'h00000100);
    corrupt = 1'b1;
    cycle(1, 1, 0, 0, 0);
    repeat (10) cycle(1, 1, 1, 0, 0);
    check_eq("redir_next_addr", acc_q[1], 32'h00000100);
    check_eq("redir_first_pc", first_pop_pc, 32'h00000100);
    check_eq("redir_no_stale", 32'(seen_dead), 32'd0);

    // Redirect + response + pop in one cycle; drop must not linger
    do_reset();
    repeat (4) cycle(1, 1, 0, 0, 0);
    check_eq("combo_pre_valid", 32'(instr_valid), 32'd1);
    cycle(1, 1, 1, 1, 32'h00000200);
    check_eq("combo_flush_valid", 32'(instr_valid), 32'd0);
    check_eq("combo_restart_req", 32'(mem_req), 32'd1);
    check_eq("combo_restart_addr", mem_addr, 32'h00000200);
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    check_eq("combo_next_valid", 32'(instr_valid), 32'd1);
    check_eq("combo_next_pc", instr_pc, 32'h00000200);

    // Address wrap at the top of the address space (redirect taken in IDLE)
    do_reset();
    cycle(1, 1, 1, 1, 32'hFFFFFFFC);
    repeat (6) cycle(1, 1, 1, 0, 0);
    check_eq("wrap_addr0", acc_q[0], 32'hFFFFFFFC);
    check_eq("wrap_addr1", acc_q[1], 32'h00000000);

    // Asynchronous reset in the middle of a wait; later stray rvalid ignored
    do_reset();
    repeat (4) cycle(1, 1, 0, 0, 0);
    check_eq("arst_pre_valid", 32'(instr_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("arst");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    stray = 1'b1;
    cycle(1, 1, 1, 0, 0);
    repeat (8) cycle(1, 1, 1, 0, 0);
    check_eq("arst_first_pc", first_pop_pc, RESET_PC);

    // Randomized traffic with varying decode back-pressure
    verbose = 1'b0;
    do_reset();
    begin
      int unsigned pops_before;
      pops_before = n_pops;
      for (int seg = 0; seg < 15; seg++) begin
        int unsigned p_ird;
        p_ird = (seg % 3 == 0) ? 10 : ((seg % 3 == 1) ? 60 : 95);
        for (int c = 0; c < 200; c++) begin
          logic [31:0] tgt;
          bit          rd;
          tgt = $urandom;
          if ($urandom_range(0, 3) == 0) tgt = 32'hFFFFFFF0 | {28'h0, tgt[3:0]};
`ifdef FETCH_MISALIGN_CHECK_EN
          tgt[1:0] = 2'b00;
`endif
          rd = ($urandom_range(0, 99) < 4);
          cycle($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60,
                $urandom_range(0, 99) < p_ird, rd, tgt);
        end
      end
      check_eq("random_liveness", 32'(n_pops - pops_before >= 100), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
